// File: rtl/pipe_wb_arb.sv
// Writeback-port arbiter: pipeline results vs. buffered long-latency results on one regfile write port.
// Optional starvation guard enabled by defining WB_ARB_STARVE_EN.
module pipe_wb_arb #(
  parameter int unsigned LU_DEPTH   = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pipe_valid_i,
  output logic        pipe_ready_o,
  input  logic        pipe_wen_i,
  input  logic [4:0]  pipe_rd_i,
  input  logic [31:0] pipe_wdata_i,
  input  logic        lu_valid_i,
  output logic        lu_ready_o,
  input  logic [4:0]  lu_rd_i,
  input  logic [31:0] lu_wdata_i,
  output logic        rf_wen_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_wdata_o,
  output logic        busy_o
);

  localparam int unsigned AW = (LU_DEPTH > 1) ? $clog2(LU_DEPTH) : 1;

  logic [AW:0]   wptr, rptr;
  logic [4:0]    mem_rd   [LU_DEPTH];
  logic [31:0]   mem_data [LU_DEPTH];
  logic          empty, full, push, pop, pipe_req, force_lu;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;
  logic          wb_wen;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;

  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head_rd   = mem_rd[rptr[AW-1:0]];
  assign head_data = mem_data[rptr[AW-1:0]];

  assign lu_ready_o   = !full;
  assign pipe_ready_o = !force_lu;
  assign busy_o       = !empty;

  assign push     = lu_valid_i && !full;
  assign pipe_req = pipe_valid_i && pipe_ready_o && pipe_wen_i && (pipe_rd_i != 5'd0);
  assign pop      = !empty && (!pipe_req || force_lu);

`ifdef WB_ARB_STARVE_EN
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;

  assign force_lu = (starve_cnt == CW'(STARVE_MAX)) && !empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt <= '0;
    end else if (empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign force_lu = 1'b0;
`endif

  // force_lu blocks the pipeline beat, so pipe_req is already low when forcing.
  always_comb begin
    wb_wen  = 1'b0;
    wb_rd   = pipe_rd_i;
    wb_data = pipe_wdata_i;
    if (pipe_req) begin
      wb_wen = 1'b1;
    end else if (pop && (head_rd != 5'd0)) begin
      wb_wen  = 1'b1;
      wb_rd   = head_rd;
      wb_data = head_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_rd[wptr[AW-1:0]]   <= lu_rd_i;
      mem_data[wptr[AW-1:0]] <= lu_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_wen_o   <= 1'b0;
      rf_rd_o    <= '0;
      rf_wdata_o <= '0;
    end else begin
      rf_wen_o <= wb_wen;
      if (wb_wen) begin
        rf_rd_o    <= wb_rd;
        rf_wdata_o <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_wb_arb.sv
// Directed self-checking bench for pipe_wb_arb (LU_DEPTH=2, STARVE_MAX=4).
module tb_pipe_wb_arb;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        pipe_valid_i = 1'b0;
  logic        pipe_ready_o;
  logic        pipe_wen_i = 1'b0;
  logic [4:0]  pipe_rd_i = '0;
  logic [31:0] pipe_wdata_i = '0;
  logic        lu_valid_i = 1'b0;
  logic        lu_ready_o;
  logic [4:0]  lu_rd_i = '0;
  logic [31:0] lu_wdata_i = '0;
  logic        rf_wen_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_wdata_o;
  logic        busy_o;

  int unsigned total = 0;
  int unsigned bad = 0;

  pipe_wb_arb #(.LU_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .pipe_valid_i(pipe_valid_i), .pipe_ready_o(pipe_ready_o), .pipe_wen_i(pipe_wen_i),
    .pipe_rd_i(pipe_rd_i), .pipe_wdata_i(pipe_wdata_i),
    .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o), .lu_rd_i(lu_rd_i), .lu_wdata_i(lu_wdata_i),
    .rf_wen_o(rf_wen_o), .rf_rd_o(rf_rd_o), .rf_wdata_o(rf_wdata_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rf_is(input string tag, input logic wen, input logic [4:0] rd, input logic [31:0] d);
    check({tag, ".wen"}, {31'd0, rf_wen_o}, {31'd0, wen});
    check({tag, ".rd"}, {27'd0, rf_rd_o}, {27'd0, rd});
    check({tag, ".data"}, rf_wdata_o, d);
  endtask

  task automatic set_pipe(input logic v, input logic wen, input logic [4:0] rd, input logic [31:0] d);
    pipe_valid_i = v; pipe_wen_i = wen; pipe_rd_i = rd; pipe_wdata_i = d;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lu_valid_i = v; lu_rd_i = rd; lu_wdata_i = d;
  endtask

  initial begin
    // reset state
    #12;
    rf_is("rst", 1'b0, 5'd0, 32'h0);
    check("rst.busy", {31'd0, busy_o}, 32'd0);
    check("rst.lu_ready", {31'd0, lu_ready_o}, 32'd1);
    check("rst.pipe_ready", {31'd0, pipe_ready_o}, 32'd1);
    tick();
    rst_ni = 1'b1;
    tick();

    // single LU result through the FIFO with idle pipeline
    set_lu(1'b1, 5'd5, 32'h11);
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
    check("lu1.busy", {31'd0, busy_o}, 32'd1);
    check("lu1.wen_early", {31'd0, rf_wen_o}, 32'd0);
    tick();
    rf_is("lu1.wr", 1'b1, 5'd5, 32'h11);
    check("lu1.busy_clr", {31'd0, busy_o}, 32'd0);
    tick();
    rf_is("lu1.hold", 1'b0, 5'd5, 32'h11);

    // pipeline write beats FIFO head in the same cycle
    set_lu(1'b1, 5'd4, 32'hB);
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
    set_pipe(1'b1, 1'b1, 5'd3, 32'hA);
    tick();
    set_pipe(1'b0, 1'b0, 5'd0, 32'h0);
    rf_is("prio.pipe", 1'b1, 5'd3, 32'hA);
    check("prio.busy", {31'd0, busy_o}, 32'd1);
    tick();
    rf_is("prio.lu", 1'b1, 5'd4, 32'hB);
    tick();

    // fill FIFO under a pipeline write stream; third beat must be held
    set_pipe(1'b1, 1'b1, 5'd7, 32'h100);
    set_lu(1'b1, 5'd8, 32'h21);
    check("full.rdy0", {31'd0, lu_ready_o}, 32'd1);
    tick();
    rf_is("full.p0", 1'b1, 5'd7, 32'h100);
    check("full.rdy1", {31'd0, lu_ready_o}, 32'd1);
    set_pipe(1'b1, 1'b1, 5'd7, 32'h101);
    set_lu(1'b1, 5'd9, 32'h22);
    tick();
    rf_is("full.p1", 1'b1, 5'd7, 32'h101);
    set_pipe(1'b1, 1'b1, 5'd7, 32'h102);
    set_lu(1'b1, 5'd10, 32'h23);
    check("full.rdy2", {31'd0, lu_ready_o}, 32'd0);
    tick();
    rf_is("full.p2", 1'b1, 5'd7, 32'h102);
    set_pipe(1'b0, 1'b0, 5'd0, 32'h0);
    check("full.rdy3", {31'd0, lu_ready_o}, 32'd0);
    tick();
    rf_is("full.a", 1'b1, 5'd8, 32'h21);
    check("full.rdy4", {31'd0, lu_ready_o}, 32'd1);
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
    rf_is("full.b", 1'b1, 5'd9, 32'h22);
    check("full.busy", {31'd0, busy_o}, 32'd1);
    tick();
    rf_is("full.c", 1'b1, 5'd10, 32'h23);
    check("full.empty", {31'd0, busy_o}, 32'd0);
    tick();

    // rd=0 and wen=0 beats consume without writing
    set_pipe(1'b1, 1'b1, 5'd0, 32'h55);
    set_lu(1'b1, 5'd0, 32'h66);
    check("zero.pready", {31'd0, pipe_ready_o}, 32'd1);
    check("zero.lready", {31'd0, lu_ready_o}, 32'd1);
    tick();
    set_pipe(1'b1, 1'b0, 5'd6, 32'h77);
    set_lu(1'b0, 5'd0, 32'h0);
    rf_is("zero.pipe", 1'b0, 5'd10, 32'h23);
    check("zero.busy", {31'd0, busy_o}, 32'd1);
    tick();
    set_pipe(1'b0, 1'b0, 5'd0, 32'h0);
    rf_is("zero.lu", 1'b0, 5'd10, 32'h23);
    check("zero.drained", {31'd0, busy_o}, 32'd0);
    tick();

    // pipeline write stream with one buffered entry
    set_lu(1'b1, 5'd12, 32'h33);
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
`ifdef WB_ARB_STARVE_EN
    for (int i = 1; i <= 4; i++) begin
      set_pipe(1'b1, 1'b1, 5'd13, 32'h40 + i);
      check("starve.ready", {31'd0, pipe_ready_o}, 32'd1);
      tick();
      rf_is("starve.pipe", 1'b1, 5'd13, 32'h40 + i);
    end
    set_pipe(1'b1, 1'b1, 5'd13, 32'h45);
    check("starve.force", {31'd0, pipe_ready_o}, 32'd0);
    tick();
    rf_is("starve.lu", 1'b1, 5'd12, 32'h33);
    check("starve.release", {31'd0, pipe_ready_o}, 32'd1);
    tick();
    rf_is("starve.held", 1'b1, 5'd13, 32'h45);
`else
    for (int i = 1; i <= 6; i++) begin
      set_pipe(1'b1, 1'b1, 5'd13, 32'h40 + i);
      check("strict.ready", {31'd0, pipe_ready_o}, 32'd1);
      tick();
      rf_is("strict.pipe", 1'b1, 5'd13, 32'h40 + i);
      check("strict.busy", {31'd0, busy_o}, 32'd1);
    end
    set_pipe(1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    rf_is("strict.lu", 1'b1, 5'd12, 32'h33);
`endif
    set_pipe(1'b0, 1'b0, 5'd0, 32'h0);
    tick();

    // asynchronous reset with two buffered entries and a write in flight
    set_pipe(1'b1, 1'b1, 5'd20, 32'h200);
    set_lu(1'b1, 5'd21, 32'h300);
    tick();
    set_pipe(1'b1, 1'b1, 5'd20, 32'h201);
    set_lu(1'b1, 5'd22, 32'h301);
    tick();
    set_pipe(1'b0, 1'b0, 5'd0, 32'h0);
    set_lu(1'b0, 5'd0, 32'h0);
    rf_is("arst.pre", 1'b1, 5'd20, 32'h201);
    check("arst.full", {31'd0, lu_ready_o}, 32'd0);
    #2;
    rst_ni = 1'b0;
    #1;
    rf_is("arst", 1'b0, 5'd0, 32'h0);
    check("arst.busy", {31'd0, busy_o}, 32'd0);
    check("arst.lu_ready", {31'd0, lu_ready_o}, 32'd1);
    check("arst.pipe_ready", {31'd0, pipe_ready_o}, 32'd1);
    tick();
    rst_ni = 1'b1;
    tick();
    rf_is("arst.after", 1'b0, 5'd0, 32'h0);
    check("arst.after_busy", {31'd0, busy_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
